// File: rtl/audio_i2s_tx_if.sv
// Sample stream from the audio mixer into the I2S output stage.
// The mixer drives (master); audio_i2s_tx consumes (slave).
interface audio_i2s_tx_if;
    logic               sample_ce;
    logic signed [15:0] sample_in;
    logic               mute;

    modport master (output sample_ce, sample_in, mute);
    modport slave  (input  sample_ce, sample_in, mute);
endinterface

// File: rtl/audio_i2s_tx.sv
// Philips I2S stereo transmitter with a small sample FIFO; the mono word is sent on both channels.
// Define AUDIO_I2S_STATUS_EN to build the saturating overflow/underflow counters.
module audio_i2s_tx #(
    parameter int BCLK_DIV = 4,
    parameter int FIFO_AW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    audio_i2s_tx_if.slave    src,
    output logic             i2s_bclk,
    output logic             i2s_lrck,
    output logic             i2s_data,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow,
    output logic             underflow,
    output logic [7:0]       ovf_count,
    output logic [7:0]       unf_count
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [15:0]      shift_q;
    logic [15:0]      frame_word;
    logic [15:0]      hold;
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [15:0]      mem [DEPTH];

    logic             tick;
    logic             fall_ev;
    logic [4:0]       bit_next;
    logic             frame_start;
    logic             right_start;
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_pop;
    logic             do_push;
    logic             ovf_ev;
    logic             unf_ev;
    logic [15:0]      head;
    logic [15:0]      next_word;
    logic [FIFO_AW:0] wr_ptr_next;
    logic [FIFO_AW:0] rd_ptr_next;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        tick        = (div_cnt == DIV_LAST);
        fall_ev     = tick & i2s_bclk;
        bit_next    = bit_cnt + 5'd1;
        frame_start = fall_ev & (bit_next == 5'd0);
        right_start = fall_ev & (bit_next == 5'd16);

        // The level register is only ever 0..DEPTH, so its MSB alone marks full.
        fifo_empty  = (fifo_level == '0);
        fifo_full   = fifo_level[FIFO_AW];
        head        = mem[rd_ptr[FIFO_AW-1:0]];

        // A frame-start pop frees a slot for a push landing in the same clk.
        do_pop      = frame_start & ~fifo_empty;
        do_push     = src.sample_ce & (~fifo_full | do_pop);
        ovf_ev      = src.sample_ce & ~do_push;
        unf_ev      = frame_start & fifo_empty;

        next_word   = do_pop ? head : hold;
        if (src.mute) begin
            next_word = 16'h0000;
        end

        wr_ptr_next = wr_ptr + {{FIFO_AW{1'b0}}, do_push};
        rd_ptr_next = rd_ptr + {{FIFO_AW{1'b0}}, do_pop};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= 5'd31;
            i2s_bclk   <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_data   <= 1'b0;
            shift_q    <= '0;
            frame_word <= '0;
            hold       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                i2s_bclk <= ~i2s_bclk;
            end

            if (fall_ev) begin
                bit_cnt  <= bit_next;
                // Word select leads the channel's MSB by one bclk.
                i2s_lrck <= (bit_next >= 5'd15) && (bit_next <= 5'd30);
                if (frame_start) begin
                    frame_word <= next_word;
                    i2s_data   <= next_word[15];
                    shift_q    <= {next_word[14:0], 1'b0};
                    if (do_pop) begin
                        hold <= head;
                    end
                end else if (right_start) begin
                    i2s_data <= frame_word[15];
                    shift_q  <= {frame_word[14:0], 1'b0};
                end else begin
                    i2s_data <= shift_q[15];
                    shift_q  <= {shift_q[14:0], 1'b0};
                end
            end

            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            fifo_level <= wr_ptr_next - rd_ptr_next;
            overflow   <= ovf_ev;
            underflow  <= unf_ev;
        end
    end

    // NOTE: storage is left unreset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= src.sample_in;
        end
    end

`ifdef AUDIO_I2S_STATUS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            if (ovf_ev && (ovf_count != 8'hFF)) begin
                ovf_count <= ovf_count + 8'd1;
            end
            if (unf_ev && (unf_count != 8'hFF)) begin
                unf_count <= unf_count + 8'd1;
            end
        end
    end
`else
    assign ovf_count = 8'h00;
    assign unf_count = 8'h00;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: a frame-level reference model and an I2S receiver
// that decodes the serial output are compared against each other.
module tb_audio_i2s_tx;
    localparam int D      = 2;
    localparam int AW     = 2;
    localparam int DEPTH  = 4;
    localparam int FS0    = 2 * D;
    localparam int FRAME  = 64 * D;
    localparam logic [31:0] WS_EXP = 32'h0001_FFFE;
`ifdef AUDIO_I2S_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic [31:0] ws;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i2s_bclk, i2s_lrck, i2s_data;
    logic [AW:0] fifo_level;
    logic        overflow, underflow;
    logic [7:0]  ovf_count, unf_count;

    audio_i2s_tx_if sif ();

    audio_i2s_tx #(.BCLK_DIV(D), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .src        (sif),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_data   (i2s_data),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underflow  (underflow),
        .ovf_count  (ovf_count),
        .unf_count  (unf_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] exp_q[$];
    logic [15:0] mhold;
    int          m_ovf, m_unf, unf_events, cyc;

    // Receiver state
    frame_t      rx_q[$];
    logic [31:0] mon_d, mon_ws;
    logic        mon_prev, mon_skip;
    int          mon_n;

    // Receiver: samples data and word select on each bclk rise; the rise before the first fall is idle.
    always @(negedge clk) begin
        if (reset) begin
            mon_prev = 1'b0;
            mon_skip = 1'b1;
            mon_n    = 0;
        end else begin
            if (i2s_bclk && !mon_prev) begin
                if (mon_skip) begin
                    mon_skip = 1'b0;
                end else begin
                    mon_d  = {mon_d[30:0], i2s_data};
                    mon_ws = {mon_ws[30:0], i2s_lrck};
                    mon_n++;
                    if (mon_n == 32) begin
                        rx_q.push_back('{d: mon_d, ws: mon_ws});
                        mon_n = 0;
                    end
                end
            end
            mon_prev = i2s_bclk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fs(input int c);
        return (c >= FS0) && (((c - FS0) % FRAME) == 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        rx_q.delete();
        mhold = 16'h0000;
        m_ovf = 0;
        m_unf = 0;
        cyc   = 0;
    endtask

    task automatic check_frames();
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            frame_t      f;
            logic [15:0] w;
            f = rx_q.pop_front();
            w = exp_q.pop_front();
            check("frame_data", f.d, {w, w});
            check("frame_ws", f.ws, WS_EXP);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bclk"}, i2s_bclk, 0);
        check({tag, "_lrck"}, i2s_lrck, 0);
        check({tag, "_data"}, i2s_data, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_unf"}, underflow, 0);
        check({tag, "_ovf_cnt"}, ovf_count, 0);
        check({tag, "_unf_cnt"}, unf_count, 0);
    endtask

    // One clk: drive at negedge, update the model at the posedge, check at the next negedge.
    task automatic step(input logic ce, input logic [15:0] d);
        logic fs, pop_ok, e_ovf, e_unf;
        sif.sample_ce = ce;
        sif.sample_in = d;
        @(posedge clk);
        cyc++;
        fs     = is_fs(cyc);
        pop_ok = fs && (mq.size() > 0);
        e_unf  = fs && (mq.size() == 0);
        e_ovf  = ce && (mq.size() == DEPTH) && !pop_ok;
        if (pop_ok) mhold = mq.pop_front();
        if (fs) exp_q.push_back(sif.mute ? 16'h0000 : mhold);
        if (ce && !e_ovf) mq.push_back(d);
        if (e_ovf && m_ovf < 255) m_ovf++;
        if (e_unf && m_unf < 255) m_unf++;
        if (e_unf) unf_events++;
        @(negedge clk);
        check("overflow", overflow, e_ovf);
        check("underflow", underflow, e_unf);
        check("fifo_level", fifo_level, mq.size());
        check("ovf_count", ovf_count, STATUS ? m_ovf : 0);
        check("unf_count", unf_count, STATUS ? m_unf : 0);
        check_frames();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
    endtask

    task automatic to_fs();
        while (!is_fs(cyc + 1)) step(1'b0, 16'h0000);
    endtask

    task automatic drain();
        while (mq.size() > 0) begin
            to_fs();
            step(1'b0, 16'h0000);
        end
    endtask

    initial begin
        sif.sample_ce = 1'b0;
        sif.sample_in = 16'h0000;
        sif.mute      = 1'b0;
        reset         = 1'b1;
        unf_events    = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        // Idle start: first frame carries zeros and underflows.
        idle(20);

        // Single known word.
        step(1'b1, 16'hA5C3);
        to_fs();
        step(1'b0, 16'h0000);

        // Six back-to-back pushes into an empty FIFO: two are dropped.
        idle(10);
        for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom));
        check("ovf_after_burst", ovf_count, STATUS ? 2 : 0);

        // Push on the frame-start pop of a full FIFO.
        to_fs();
        step(1'b1, 16'($urandom));
        check("full_push_pop_level", fifo_level, 4);
        drain();

        // Mute at frame start blanks the word but still pops it; mid-frame changes wait a frame.
        idle(5);
        step(1'b1, 16'h7FFF);
        sif.mute = 1'b1;
        to_fs();
        step(1'b0, 16'h0000);
        check("mute_pop_level", fifo_level, 0);
        idle(30);
        sif.mute = 1'b0;
        to_fs();
        step(1'b0, 16'h0000);
        idle(40);
        sif.mute = 1'b1;
        to_fs();
        step(1'b0, 16'h0000);
        idle(20);
        sif.mute = 1'b0;

        // Randomized traffic across several frames.
        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 199) == 0) sif.mute = ~sif.mute;
            step(($urandom_range(0, 59) == 0), 16'($urandom));
        end
        sif.mute = 1'b0;
        drain();

        // 0x8000 repeats from hold with one underflow per frame until the counter saturates.
        idle(10);
        step(1'b1, 16'h8000);
        for (int i = 0; i < 300 * FRAME && unf_events < 260; i++) step(1'b0, 16'h0000);
        check("unf_saturated", unf_count, STATUS ? 255 : 0);

        // Reset mid-frame with samples queued.
        step(1'b1, 16'h1234);
        step(1'b1, 16'hBEEF);
        idle(40);
        check("pre_reset_pending_frames", exp_q.size(), 1);
        #2 reset = 1'b1;
        #1 check_reset_state("mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        to_fs();
        step(1'b0, 16'h0000);
        to_fs();
        step(1'b0, 16'h0000);
        check("rx_frames_drained", rx_q.size(), 0);
        check("exp_frames_pending", exp_q.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
